// File: rtl/data_wbuf_pkg.sv
// Shared definitions for the data-side store buffer: access sizes and the
// layout of one buffered store entry.
package data_wbuf_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int WBUF_ENT_WD = 2 + 4 + 32 + 32;

    typedef struct packed {
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } wbuf_ent_t;

endpackage

// File: rtl/data_wbuf_fifo.sv
// In-order store FIFO: DEPTH entries, wrapping pointers, registered occupancy.
// The caller never pushes when full nor pops when empty.
module data_wbuf_fifo
    import data_wbuf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic                     pop,
    input  wbuf_ent_t                din,
    output wbuf_ent_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    wbuf_ent_t     mem [DEPTH];

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/data_wbuf.sv
// Store-buffering shim between the core data port and the AXI bridge.
// Stores retire to the core a cycle after acceptance; loads wait for a quiet buffer.
module data_wbuf
    import data_wbuf_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int WR_OUTS_MAX = 4
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [3:0]  out_wstrb,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    input  logic [31:0] out_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(WR_OUTS_MAX + 1);
    localparam logic [OW-1:0] OUTS_MAX = OW'(WR_OUTS_MAX);

    wbuf_ent_t     core_ent;
    wbuf_ent_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic [OW-1:0] wr_outs;
    logic          rd_busy;
    logic          st_ack;

    logic          st_accept;
    logic          ld_ok;
    logic          drain;
    logic          pop;
    logic          wr_ack;

    assign core_ent = '{size:  data_sram_size,
                        wstrb: data_sram_wstrb,
                        addr:  data_sram_addr,
                        wdata: data_sram_wdata};

    data_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (st_accept),
        .pop     (pop),
        .din     (core_ent),
        .dout    (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A load only goes out once every earlier store is acknowledged, so no
    // address compare against buffered stores is ever needed.
    always_comb begin
        st_accept = data_sram_req & data_sram_wr & ~fifo_full & ~rd_busy;
        ld_ok     = data_sram_req & ~data_sram_wr & (fifo_count == '0)
                  & (wr_outs == '0) & ~rd_busy & ~st_ack;
        drain     = ~fifo_empty & (wr_outs < OUTS_MAX);
        pop       = drain & out_addr_ok;
        wr_ack    = out_data_ok & ~rd_busy;
    end

    always_comb begin
        out_req   = 1'b0;
        out_wr    = 1'b0;
        out_size  = '0;
        out_wstrb = '0;
        out_addr  = '0;
        out_wdata = '0;
        if (drain) begin
            out_req   = 1'b1;
            out_wr    = 1'b1;
            out_size  = head.size;
            out_wstrb = head.wstrb;
            out_addr  = head.addr;
            out_wdata = head.wdata;
        end else if (ld_ok) begin
            out_req   = 1'b1;
            out_size  = data_sram_size;
            out_wstrb = data_sram_wstrb;
            out_addr  = data_sram_addr;
            out_wdata = data_sram_wdata;
        end
    end

    always_comb begin
        data_sram_addr_ok = st_accept | (ld_ok & out_addr_ok);
        data_sram_data_ok = rd_busy ? out_data_ok : st_ack;
        data_sram_rdata   = (rd_busy & out_data_ok) ? out_rdata : '0;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_outs <= '0;
            rd_busy <= 1'b0;
            st_ack  <= 1'b0;
        end else begin
            st_ack <= st_accept;
            case ({pop, wr_ack & (wr_outs != '0)})
                2'b10:   wr_outs <= wr_outs + 1'b1;
                2'b01:   wr_outs <= wr_outs - 1'b1;
                default: ;
            endcase
            if (ld_ok & out_addr_ok)
                rd_busy <= 1'b1;
            else if (rd_busy & out_data_ok)
                rd_busy <= 1'b0;
        end
    end

endmodule
